// File: rtl/scrambler_ctrl_pkg.sv
// Shared definitions for the scrambler signature block: FSM state encoding,
// default LFSR geometry and the feedback tap positions.
package scrambler_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 220;
    localparam int DEF_STEP  = 18;

    // Galois feedback taps; the MSB is the feedback source.
    localparam int TAP0 = 0;
    localparam int TAP1 = 23;
    localparam int TAP2 = 121;
    localparam int TAP3 = 168;

    function automatic logic is_tap(input int idx);
        return (idx == TAP0) || (idx == TAP1) || (idx == TAP2) || (idx == TAP3);
    endfunction

endpackage

// File: rtl/scrambler_ctrl_lfsr.sv
// lfsr_0: combinational STEP-bit advance of a Galois LFSR.
// Each step shifts left, XORs the tap mask in when the old MSB was 1, and
// XORs serial_in[i] into bit 0 (bit 0 of serial_in is applied first).
// Ports:
//   data_load  - current LFSR state
//   serial_in  - STEP serial bits
//   data_out   - state after STEP steps
module lfsr_0
    import scrambler_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP
) (
    input  logic [WIDTH-1:0] data_load,
    input  logic [STEP-1:0]  serial_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_acc;
    logic             w_fb;

    for (genvar g = 0; g < WIDTH; g++) begin : g_mask
        assign w_mask[g] = is_tap(g);
    end

    always_comb begin
        w_acc = data_load;
        w_fb  = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            w_fb     = w_acc[WIDTH-1];
            w_acc    = {w_acc[WIDTH-2:0], 1'b0} ^ (w_fb ? w_mask : '0);
            w_acc[0] = w_acc[0] ^ serial_in[i];
        end
        data_out = w_acc;
    end

endmodule

// File: rtl/scrambler_ctrl.sv
// scrambler_ctrl: folds a frame of STEP-bit words into a WIDTH-bit LFSR
// signature. A start in IDLE loads the seed; RUN accepts one word per cycle;
// HOLD presents the signature until out_ready.
// Ports:
//   clk, rst         - clock, async active-low reset
//   start, seed      - frame start (IDLE only) and initial LFSR state
//   in_valid/in_data/in_last/in_ready - word input handshake
//   out_valid/out_data/out_err/out_ready - signature output handshake
//   word_cnt         - words accepted in current/last frame (saturating)
//   busy             - not IDLE
module scrambler_ctrl
    import scrambler_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int STEP      = DEF_STEP,
    parameter int MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic             in_valid,
    input  logic [STEP-1:0]  in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    input  logic             out_ready,
    output logic [15:0]      word_cnt,
    output logic             busy
);

    // Frame-length counter is separate from word_cnt so the limit check
    // still works when MAX_WORDS exceeds the 16-bit saturating counter.
    localparam int FW = $clog2(MAX_WORDS + 1);

    state_e           r_fsm, w_fsm_nxt;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_lfsr;
    logic [15:0]      r_cnt;
    logic [FW-1:0]    r_frm;
    logic             r_err;
    logic             w_accept;
    logic             w_at_limit;

    lfsr_0 #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_lfsr (
        .data_load (r_state),
        .serial_in (in_data),
        .data_out  (w_lfsr)
    );

    assign w_accept   = in_valid & in_ready;
    assign w_at_limit = (r_frm == FW'(MAX_WORDS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fsm <= IDLE;
        else      r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (start) w_fsm_nxt = RUN;
            RUN:     if (w_accept && (in_last || w_at_limit)) w_fsm_nxt = HOLD;
            HOLD:    if (out_ready) w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_frm   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (start) begin
                        r_state <= seed;
                        r_cnt   <= '0;
                        r_frm   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_state <= w_lfsr;
                        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
                        r_frm   <= r_frm + 1'b1;
                        // A last word arriving exactly at the limit is a
                        // complete frame, not a truncation.
                        r_err   <= ~in_last & w_at_limit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_fsm == RUN);
    assign out_valid = (r_fsm == HOLD);
    assign busy      = (r_fsm != IDLE);
    assign out_data  = r_state;
    assign out_err   = r_err;
    assign word_cnt  = r_cnt;

endmodule

// File: tb/tb_scrambler_ctrl.sv
module tb_scrambler_ctrl;

    localparam int W  = 220;
    localparam int S  = 18;
    localparam int MW = 4;
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] TAPS_M = (ONE << 168) | (ONE << 121) | (ONE << 23) | ONE;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  seed = '0;
    logic          in_valid = 1'b0;
    logic [S-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, out_err, busy;
    logic [W-1:0]  out_data;
    logic [15:0]   word_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    scrambler_ctrl #(.WIDTH(W), .STEP(S), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_err(out_err), .out_ready(out_ready), .word_cnt(word_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Signature as polynomial arithmetic: multiply by x modulo the tap
    // polynomial, then add the incoming bit at x^0.
    function automatic logic [W-1:0] ref_scr(input logic [W-1:0] s, input logic [S-1:0] d);
        logic carry;
        for (int i = 0; i < S; i++) begin
            carry = s[W-1];
            s = s << 1;
            if (carry) s = s ^ TAPS_M;
            s = s ^ W'(d[i]);
        end
        return s;
    endfunction

    // Behavioural model: 0 = idle, 1 = collecting words, 2 = presenting.
    int           m_phase;
    int           m_nw;
    logic [W-1:0] m_sig;
    logic [15:0]  m_cnt;
    logic         m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0; m_nw <= 0; m_sig <= '0; m_cnt <= '0; m_err <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_sig <= seed; m_cnt <= '0; m_err <= 1'b0; m_nw <= 0; m_phase <= 1;
                end
                1: if (in_valid) begin
                    m_sig <= ref_scr(m_sig, in_data);
                    m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                    m_nw  <= m_nw + 1;
                    if (in_last) begin
                        m_phase <= 2; m_err <= 1'b0;
                    end else if (m_nw + 1 == MW) begin
                        m_phase <= 2; m_err <= 1'b1;
                    end
                end
                2: if (out_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready", 256'(in_ready), 256'(m_phase == 1));
        chk("cyc_out_valid", 256'(out_valid), 256'(m_phase == 2));
        chk("cyc_busy", 256'(busy), 256'(m_phase != 0));
        chk("cyc_word_cnt", 256'(word_cnt), 256'(m_cnt));
        if (m_phase == 2 || !rst) begin
            chk("cyc_out_data", 256'(out_data), 256'(m_sig));
            chk("cyc_out_err", 256'(out_err), 256'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] sd);
        start = 1'b1; seed = sd;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [S-1:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        step();
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    task automatic release_sig();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_valid", 256'(out_valid), 256'(0));
        chk("release_busy", 256'(busy), 256'(0));
    endtask

    logic [W-1:0] exp_v;
    logic [W-1:0] held;

    initial begin
        step(); step();
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_ready", 256'(in_ready), 256'(0));
        chk("rst_data", 256'(out_data), 256'(0));
        chk("rst_cnt", 256'(word_cnt), 256'(0));
        @(negedge clk); rst = 1'b1;
        step();
        chk("idle_ready", 256'(in_ready), 256'(0));

        // seed=1, one zero word
        do_start(ONE);
        chk("run_ready", 256'(in_ready), 256'(1));
        send_word('0, 1'b1);
        chk("a_latency", 256'(out_valid), 256'(1));
        exp_v = ONE << 18;
        chk("a_data", 256'(out_data), 256'(exp_v));
        chk("a_err", 256'(out_err), 256'(0));
        chk("a_cnt", 256'(word_cnt), 256'(1));
        release_sig();
        chk("a_cnt_idle", 256'(word_cnt), 256'(1));

        // seed=0, data bit 0
        do_start('0);
        send_word(S'(1), 1'b1);
        exp_v = ONE << 17;
        chk("b_data", 256'(out_data), 256'(exp_v));
        release_sig();

        // MSB seed exercises every tap
        do_start(ONE << 219);
        send_word('0, 1'b1);
        exp_v = (ONE << 17) | (ONE << 40) | (ONE << 138) | (ONE << 185);
        chk("c_data", 256'(out_data), 256'(exp_v));
        release_sig();

        // three back-to-back words, mixed pattern
        do_start({55{4'hA}});
        send_word(18'h2_5A5A, 1'b0);
        send_word(18'h3_FFFF, 1'b0);
        send_word(18'h0_1234, 1'b1);
        chk("d_valid", 256'(out_valid), 256'(1));
        chk("d_cnt", 256'(word_cnt), 256'(3));
        release_sig();

        // truncation at MAX_WORDS, then extra words refused
        do_start(ONE << 5);
        for (int i = 0; i < 4; i++) send_word(S'(i * 7 + 3), 1'b0);
        chk("e_valid", 256'(out_valid), 256'(1));
        chk("e_err", 256'(out_err), 256'(1));
        chk("e_cnt", 256'(word_cnt), 256'(4));
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = S'(i + 9);
            #1;
            chk("e_ready_extra", 256'(in_ready), 256'(0));
            step();
        end
        in_valid = 1'b0;
        chk("e_cnt_after", 256'(word_cnt), 256'(4));

        // hold with out_ready low, start pulsed
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            step();
            start = 1'b0;
            chk("f_hold_valid", 256'(out_valid), 256'(1));
            chk("f_hold_data", 256'(out_data), 256'(held));
        end
        // start coincident with the release is ignored
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        chk("f_rel_valid", 256'(out_valid), 256'(0));
        chk("f_rel_busy", 256'(busy), 256'(0));
        step();
        chk("f_still_idle", 256'(busy), 256'(0));

        // last word exactly at the limit is not an error
        do_start(ONE << 100);
        for (int i = 0; i < 4; i++) send_word(S'(18'h1_0001 << i), i == 3);
        chk("g_valid", 256'(out_valid), 256'(1));
        chk("g_err", 256'(out_err), 256'(0));
        release_sig();

        // reset mid-frame
        do_start(ONE);
        send_word(18'h0_00FF, 1'b0);
        send_word(18'h0_FF00, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("h_rst_busy", 256'(busy), 256'(0));
        chk("h_rst_ready", 256'(in_ready), 256'(0));
        chk("h_rst_valid", 256'(out_valid), 256'(0));
        chk("h_rst_data", 256'(out_data), 256'(0));
        chk("h_rst_err", 256'(out_err), 256'(0));
        chk("h_rst_cnt", 256'(word_cnt), 256'(0));
        @(negedge clk); #2 rst = 1'b1;
        step();
        send_word(18'h3_0000, 1'b1);
        chk("h_no_valid", 256'(out_valid), 256'(0));
        do_start(ONE);
        send_word('0, 1'b0);
        send_word('0, 1'b1);
        exp_v = ONE << 36;
        chk("h_data", 256'(out_data), 256'(exp_v));
        chk("h_cnt", 256'(word_cnt), 256'(2));
        release_sig();

        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scrambler_ctrl.md
SCRAMBLER_CTRL -- requirements
Module: scrambler_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 220: LFSR state width.
REQ-002 SHALL have parameter STEP, default 18: serial bits consumed per accepted word.
REQ-003 SHALL have parameter MAX_WORDS, default 1024: frame length limit in words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: frame-start pulse; honoured only in IDLE.
REQ-007 SHALL have port seed, input, WIDTH bits: initial LFSR state, sampled with start.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-009 SHALL have port in_data, input, STEP bits: serial bits; bit 0 is applied first.
REQ-010 SHALL have port in_last, input, 1 bit: marks the last word of the frame.
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-012 SHALL have port out_valid, output, 1 bit: the signature is valid.
REQ-013 SHALL have port out_data, output, WIDTH bits: final LFSR state (signature).
REQ-014 SHALL have port out_err, output, 1 bit: frame truncated at MAX_WORDS; qualified by out_valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream consumes the signature.
REQ-016 SHALL have port word_cnt, output, 16 bits: words accepted in the current or last frame.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and HOLD.
REQ-019 IDLE: on start=1, SHALL load state<=seed, clear word_cnt and go to RUN; in_ready=0 in IDLE.
REQ-020 RUN: in_ready SHALL be 1; a word is accepted when in_valid & in_ready.
REQ-021 On acceptance, SHALL set state<=lfsr_0(state, in_data), i.e. STEP Galois steps with taps 0, 23, 121 and 168, feedback from the MSB, and in_data[i] XORed into bit 0 at step i; word_cnt SHALL increment.
REQ-022 If the accepted word has in_last=1, SHALL go to HOLD with out_data = updated state and out_err=0.
REQ-023 If the accepted word is word number MAX_WORDS and in_last=0, SHALL go to HOLD with out_err=1.
REQ-024 Latency: out_valid SHALL rise in the cycle after the final word is accepted.
REQ-025 HOLD: out_valid=1; out_data, out_err and word_cnt SHALL remain stable until out_ready=1; in_ready=0.
REQ-026 When out_ready=1 in HOLD, SHALL go to IDLE with out_valid=0 in the next cycle.
REQ-027 start SHALL be ignored in RUN and HOLD.
REQ-028 A start in the same cycle as the HOLD-to-IDLE transition SHALL be ignored.
REQ-029 word_cnt SHALL saturate at 16'hFFFF and hold its value in IDLE until the next start.
REQ-030 No valid/ready gaps SHALL be required: back-to-back words SHALL be accepted every cycle in RUN.

Reset
REQ-031 When rst=0, SHALL asynchronously force: FSM=IDLE, state=0, word_cnt=0, in_ready=0, out_valid=0, out_err=0, out_data=0, busy=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no signature emitted; the first post-reset frame SHALL require a new start.

Structure
REQ-033 The FSM state enum, WIDTH/STEP defaults and tap positions (0, 23, 121, 168) SHALL live in a shared scrambler package.
REQ-034 The LFSR step SHALL be one instance of the existing sub-module lfsr_0 (data_load=state, serial_in=in_data); the block adds only the state register, FSM and counter.

Verification
REQ-035 seed=1, one word in_data=0 with in_last=1 -> out_data = 1<<18, out_err=0, word_cnt=1.
REQ-036 seed=0, in_data=18'h00001 with in_last=1 -> out_data = 1<<17.
REQ-037 seed=1<<219, in_data=0 with in_last=1 -> out_data has exactly bits {17, 40, 138, 185} set.
REQ-038 MAX_WORDS=4, 6 words with in_last=0 -> HOLD after word 4, out_err=1, word_cnt=4, in_ready=0 for words 5-6.
REQ-039 out_ready held low 5 cycles in HOLD, with start pulsed -> out_valid and out_data stable, start ignored, then IDLE one cycle after out_ready=1.
REQ-040 rst asserted after 2 of 3 words -> all outputs 0 immediately, no out_valid; a new start+frame then produces the correct signature.
